// File: rtl/exp_pkg.sv
// Shared constants for the sequential e^-x unit: table of e^-(2^(k-16)) in 0.32,
// FSM encoding and fixed-point geometry.
package exp_pkg;

    localparam int FRAC_W    = 16;
    localparam int LUT_DEPTH = 20;
    localparam int LUT_W     = 32;
    localparam int IDX_W     = 5;
    // Any input bit at or above this position means x >= 16: result flushes to zero.
    localparam int OVF_BIT   = FRAC_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } exp_state_e;

    localparam logic [IDX_W-1:0] K_TOP = IDX_W'(LUT_DEPTH - 1);

    // floor(2^32 * e^-(2^(k-16))), k = 0..19
    localparam logic [LUT_W-1:0] EXP_LUT [LUT_DEPTH] = '{
        32'hFFFF_0000, 32'hFFFE_0001, 32'hFFFC_0007, 32'hFFF8_001F,
        32'hFFF0_007F, 32'hFFE0_01FF, 32'hFFC0_07FF, 32'hFF80_1FFA,
        32'hFF00_7FD5, 32'hFE01_FEAB, 32'hFC07_F55F, 32'hF81F_AB54,
        32'hF07D_5FDE, 32'hE1EB_5127, 32'hC75F_7CF5, 32'h9B45_97E3,
        32'h5E2D_58D8, 32'h22A5_5547, 32'h04B0_556E, 32'h0015_FC21
    };

endpackage

// File: rtl/exp_lut_rom.sv
// Combinational ROM returning e^-(2^(idx-16)) in 0.32 format.
module exp_lut_rom
    import exp_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [LUT_W-1:0] value
);

    // Table lookup; indices past the table read as zero.
    always_comb begin
        if (idx < IDX_W'(LUT_DEPTH)) begin
            value = EXP_LUT[idx];
        end else begin
            value = {LUT_W{1'b0}};
        end
    end

endmodule

// File: rtl/exp_seq_ctrl.sv
// Bit-serial e^-x: multiplies table entries for each set bit of x, one bit per cycle
// through a single shared multiplier, and accumulates a saturating per-vector sum.
module exp_seq_ctrl
    import exp_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int SUM_SIZE  = 40
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic                 in_valid_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    output logic [DATA_SIZE-1:0] exp_data_o,
    output logic                 exp_valid_o,
    input  logic                 exp_ready_i,
    output logic [SUM_SIZE-1:0]  sum_data_o,
    output logic                 sum_valid_o
);

    exp_state_e             state_r, state_s;
    logic [LUT_W-1:0]       acc_r, acc_s;
    logic [IDX_W-1:0]       k_r, k_s;
    logic                   empty_r, empty_s;
    logic [DATA_SIZE-1:0]   x_r, x_s;
    logic                   last_r, last_s;
    logic [LUT_W-1:0]       lut_s;
    logic [2*LUT_W-1:0]     prod_s;
    logic                   in_ready_r, exp_valid_r, sum_valid_r;
    logic [DATA_SIZE-1:0]   exp_data_r;
    logic [SUM_SIZE-1:0]    sum_r, sum_data_r, sum_sat_s;
    logic [SUM_SIZE:0]      sum_add_s;
    logic                   hs_s;

    exp_lut_rom u_lut (
        .idx   (k_r),
        .value (lut_s)
    );

    assign prod_s = {{LUT_W{1'b0}}, acc_r} * {{LUT_W{1'b0}}, lut_s};
    assign hs_s   = exp_valid_r & exp_ready_i;

    // Next-state and datapath update for the IDLE/ITER/DONE sequencer.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        k_s     = k_r;
        empty_s = empty_r;
        x_s     = x_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i && in_ready_r) begin
                    x_s     = in_data_i;
                    last_s  = in_last_i;
                    k_s     = K_TOP;
                    empty_s = 1'b1;
                    if (in_data_i == {DATA_SIZE{1'b0}}) begin
                        acc_s   = {LUT_W{1'b1}};
                        state_s = ST_DONE;
                    end else if (|in_data_i[DATA_SIZE-1:OVF_BIT]) begin
                        acc_s   = {LUT_W{1'b0}};
                        state_s = ST_DONE;
                    end else begin
                        acc_s   = {LUT_W{1'b0}};
                        state_s = ST_ITER;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (x_r[k_r]) begin
                    if (empty_r) begin
                        acc_s   = lut_s;
                        empty_s = 1'b0;
                    end else begin
                        acc_s = prod_s[2*LUT_W-1:LUT_W];
                    end
                end else begin
                    acc_s = acc_r;
                end
                if (k_r == {IDX_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    k_s = k_r - {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Saturating add of the current result into the vector sum.
    always_comb begin
        sum_add_s = {1'b0, sum_r} + {{(SUM_SIZE+1-DATA_SIZE){1'b0}}, exp_data_r};
        if (sum_add_s[SUM_SIZE]) begin
            sum_sat_s = {SUM_SIZE{1'b1}};
        end else begin
            sum_sat_s = sum_add_s[SUM_SIZE-1:0];
        end
    end

    // Sequencer state and iteration registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
            acc_r   <= {LUT_W{1'b0}};
            k_r     <= {IDX_W{1'b0}};
            empty_r <= 1'b0;
            x_r     <= {DATA_SIZE{1'b0}};
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            k_r     <= k_s;
            empty_r <= empty_s;
            x_r     <= x_s;
            last_r  <= last_s;
        end
    end

    // Registered handshake outputs and the per-vector sum.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_ready_r  <= 1'b0;
            exp_valid_r <= 1'b0;
            exp_data_r  <= {DATA_SIZE{1'b0}};
            sum_r       <= {SUM_SIZE{1'b0}};
            sum_data_r  <= {SUM_SIZE{1'b0}};
            sum_valid_r <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_IDLE);
            // Result is published one cycle after DONE is entered.
            if ((state_r == ST_DONE) && !exp_valid_r) begin
                exp_valid_r <= 1'b1;
                exp_data_r  <= DATA_SIZE'(acc_r);
            end else if (hs_s) begin
                exp_valid_r <= 1'b0;
            end
            sum_valid_r <= 1'b0;
            if (hs_s) begin
                if (last_r) begin
                    sum_data_r  <= sum_sat_s;
                    sum_valid_r <= 1'b1;
                    sum_r       <= {SUM_SIZE{1'b0}};
                end else begin
                    sum_r <= sum_sat_s;
                end
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign exp_valid_o = exp_valid_r;
    assign exp_data_o  = exp_data_r;
    assign sum_valid_o = sum_valid_r;
    assign sum_data_o  = sum_data_r;

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// Directed self-checking bench for exp_seq_ctrl.
module tb_exp_seq_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic [31:0] exp_data_o;
    logic        exp_valid_o;
    logic        exp_ready_i;
    logic [39:0] sum_data_o;
    logic        sum_valid_o;

    int tests = 0;
    int fails = 0;

    logic [63:0] p3;
    logic [31:0] exp3;

    exp_seq_ctrl #(.DATA_SIZE(32), .SUM_SIZE(40)) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .exp_data_o  (exp_data_o),
        .exp_valid_o (exp_valid_o),
        .exp_ready_i (exp_ready_i),
        .sum_data_o  (sum_data_o),
        .sum_valid_o (sum_valid_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Send one element, then wait (bounded) for exp_valid_o and check latency and value.
    task automatic do_elem(input string tag, input logic [31:0] data, input logic last,
                           input int exp_lat, input logic [31:0] exp_val);
        int lat;
        in_data_i  = data;
        in_last_i  = last;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check({tag, "_rdy_low"}, {63'd0, in_ready_o}, 64'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!exp_valid_o && lat < 40);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, {32'd0, exp_data_o}, {32'd0, exp_val});
    endtask

    // Complete the exp handshake and check the resulting sum pulse (or its absence).
    task automatic hs(input string tag, input logic exp_sv, input logic [39:0] exp_sum);
        exp_ready_i = 1'b1;
        tick();
        exp_ready_i = 1'b0;
        check({tag, "_vld_drop"}, {63'd0, exp_valid_o}, 64'd0);
        check({tag, "_rdy_back"}, {63'd0, in_ready_o}, 64'd1);
        check({tag, "_sum_vld"}, {63'd0, sum_valid_o}, {63'd0, exp_sv});
        if (exp_sv) begin
            check({tag, "_sum"}, {24'd0, sum_data_o}, {24'd0, exp_sum});
            tick();
            check({tag, "_sum_pulse"}, {63'd0, sum_valid_o}, 64'd0);
        end
    endtask

    initial begin
        reset_n_i   = 1'b0;
        in_data_i   = 32'd0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        exp_ready_i = 1'b0;
        p3   = 64'h22A5_5547 * 64'h5E2D_58D8;
        exp3 = p3[63:32];

        #2;
        check("rst_rdy", {63'd0, in_ready_o}, 64'd0);
        check("rst_vld", {63'd0, exp_valid_o}, 64'd0);
        check("rst_data", {32'd0, exp_data_o}, 64'd0);
        check("rst_svld", {63'd0, sum_valid_o}, 64'd0);
        check("rst_sum", {24'd0, sum_data_o}, 64'd0);
        #10 reset_n_i = 1'b1;
        tick();
        check("rel_rdy", {63'd0, in_ready_o}, 64'd1);

        // Single-element vectors: one, zero, overflow, three.
        do_elem("x1", 32'h0001_0000, 1'b1, 21, 32'h5E2D_58D8);
        hs("x1", 1'b1, 40'h00_5E2D_58D8);
        do_elem("x0", 32'h0000_0000, 1'b1, 1, 32'hFFFF_FFFF);
        hs("x0", 1'b1, 40'h00_FFFF_FFFF);
        do_elem("x16", 32'h0010_0000, 1'b1, 1, 32'h0000_0000);
        hs("x16", 1'b1, 40'h00_0000_0000);
        do_elem("x3", 32'h0003_0000, 1'b1, 21, exp3);
        hs("x3", 1'b1, {8'd0, exp3});

        // Downstream stall for 5 cycles in DONE.
        do_elem("stall", 32'h0001_0000, 1'b1, 21, 32'h5E2D_58D8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_vld", {63'd0, exp_valid_o}, 64'd1);
            check("stall_data", {32'd0, exp_data_o}, 64'h5E2D_58D8);
            check("stall_rdy", {63'd0, in_ready_o}, 64'd0);
            check("stall_svld", {63'd0, sum_valid_o}, 64'd0);
        end
        hs("stall", 1'b1, 40'h00_5E2D_58D8);

        // Three-element vector, then a fresh vector starting from zero.
        do_elem("v0", 32'h0000_0000, 1'b0, 1, 32'hFFFF_FFFF);
        hs("v0", 1'b0, 40'd0);
        do_elem("v1", 32'h0000_0000, 1'b0, 1, 32'hFFFF_FFFF);
        hs("v1", 1'b0, 40'd0);
        do_elem("v2", 32'h0001_0000, 1'b1, 21, 32'h5E2D_58D8);
        hs("v2", 1'b1, 40'h02_5E2D_58D6);
        do_elem("nv", 32'h0000_0000, 1'b1, 1, 32'hFFFF_FFFF);
        hs("nv", 1'b1, 40'h00_FFFF_FFFF);

        // 257 * 0xFFFFFFFF exceeds 40 bits: sum saturates.
        for (int i = 0; i < 257; i++) begin
            do_elem("sat", 32'h0000_0000, (i == 256), 1, 32'hFFFF_FFFF);
            hs("sat", (i == 256), 40'hFF_FFFF_FFFF);
        end

        // Reset during ITER at k=10 with a partial vector pending.
        do_elem("part", 32'h0000_0000, 1'b0, 1, 32'hFFFF_FFFF);
        hs("part", 1'b0, 40'd0);
        in_data_i  = 32'h0001_0000;
        in_last_i  = 1'b1;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (9) tick();
        reset_n_i = 1'b0;
        #1;
        check("arst_rdy", {63'd0, in_ready_o}, 64'd0);
        check("arst_vld", {63'd0, exp_valid_o}, 64'd0);
        check("arst_data", {32'd0, exp_data_o}, 64'd0);
        check("arst_svld", {63'd0, sum_valid_o}, 64'd0);
        check("arst_sum", {24'd0, sum_data_o}, 64'd0);
        #2 reset_n_i = 1'b1;
        tick();
        check("arel_rdy", {63'd0, in_ready_o}, 64'd1);
        do_elem("post", 32'h0001_0000, 1'b1, 21, 32'h5E2D_58D8);
        hs("post", 1'b1, 40'h00_5E2D_58D8);
        do_elem("post3", 32'h0003_0000, 1'b1, 21, exp3);
        hs("post3", 1'b1, {8'd0, exp3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exp_seq_ctrl.md
EXP_SEQ_CTRL -- requirements
Module: exp_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of the input word and of the exp result.
REQ-002 SHALL have parameter SUM_SIZE, default 40: width of the running-sum accumulator.
REQ-003 SHALL have port clock_i, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data_i, input, DATA_SIZE bits: exponent magnitude x, unsigned, 16 fraction bits; the block computes e^-x.
REQ-006 SHALL have port in_valid_i, input, 1 bit: in_data_i and in_last_i are valid.
REQ-007 SHALL have port in_last_i, input, 1 bit: the element is the last of its vector.
REQ-008 SHALL have port in_ready_o, output, 1 bit: the block can accept an element.
REQ-009 SHALL have port exp_data_o, output, DATA_SIZE bits: e^-x in 0.32 unsigned format.
REQ-010 SHALL have port exp_valid_o, output, 1 bit: exp_data_o is valid.
REQ-011 SHALL have port exp_ready_i, input, 1 bit: the downstream stage accepts exp_data_o.
REQ-012 SHALL have port sum_data_o, output, SUM_SIZE bits: sum of the exp results for the vector.
REQ-013 SHALL have port sum_valid_o, output, 1 bit: single-cycle pulse marking sum_data_o valid.

Function
REQ-014 SHALL implement the FSM IDLE -> ITER -> DONE -> IDLE; in_ready_o=1 only in IDLE.
REQ-015 SHALL, on accept (in_valid_i & in_ready_o), capture in_data_i and in_last_i, set bit index k=19, set acc_empty=1.
REQ-016 SHALL treat in_data_i==0 as a special case: go directly to DONE with result 32'hFFFFFFFF.
REQ-017 SHALL treat any of in_data_i[31:20] set as a special case: go directly to DONE with result 0.
REQ-018 SHALL process one bit per ITER cycle, k=19..0: bit set & acc_empty -> acc=LUT[k], acc_empty=0; bit set & !acc_empty -> acc=(acc*LUT[k])[63:32]; bit clear -> acc unchanged.
REQ-019 SHALL use one shared 32x32 multiplier for all ITER steps.
REQ-020 SHALL enter DONE after the k=0 step, so exp_valid_o rises exactly 21 cycles after the accept edge (1 cycle for the special cases).
REQ-021 SHALL hold exp_valid_o and exp_data_o stable in DONE until exp_ready_i=1, then return to IDLE on the next edge.
REQ-022 SHALL, on each exp handshake, add exp_data_o (zero-extended) to the sum accumulator, saturating at all-ones.
REQ-023 SHALL, when the handshaken element had in_last_i=1, pulse sum_valid_o for 1 cycle on the following cycle with the final sum, and clear the accumulator in that same cycle.
REQ-024 SHALL give bit-exact results for non-special inputs equal to the sequential 20-step LUT product above.

Reset
REQ-025 SHALL, on reset_n_i=0 at any time (including mid-ITER or mid-DONE), immediately force: state=IDLE, acc=0, k=0, sum=0, exp_data_o=0, exp_valid_o=0, sum_valid_o=0, in_ready_o=0.
REQ-026 SHALL raise in_ready_o on the first clock edge after reset deassertion; a partial vector in flight at reset is discarded.

Structure
REQ-027 SHALL place the 20-entry 0.32 table e^-(2^(k-16)), k=0..19, the FSM state encoding and the 16-bit fraction-width constant in the shared package exp_pkg.
REQ-028 SHALL implement the table as the sub-module exp_lut_rom: combinational, 5-bit index in, 32-bit constant out.

Verification
REQ-029 SHALL cover: in_data_i=32'h0001_0000 -> exp_data_o=32'h5E2D_58D8, exp_valid_o 21 cycles after accept.
REQ-030 SHALL cover: in_data_i=0 -> exp_data_o=32'hFFFF_FFFF; in_data_i=32'h0010_0000 -> exp_data_o=0; each 1 cycle after accept.
REQ-031 SHALL cover: in_data_i=32'h0003_0000 -> exp_data_o=floor(32'h22A5_5547*32'h5E2D_58D8/2^32).
REQ-032 SHALL cover: exp_ready_i held 0 for 5 cycles in DONE -> exp_data_o stable, in_ready_o=0, no sum update until the handshake.
REQ-033 SHALL cover: vector of 3 elements {0, 0, 32'h0001_0000}, last on the third -> one sum_valid_o pulse, sum=2*32'hFFFF_FFFF+32'h5E2D_58D8; the next vector starts from sum=0.
REQ-034 SHALL cover: reset asserted at ITER k=10 -> all outputs cleared asynchronously; after release, a new element computes correctly.
